// File: rtl/signed_nr_div_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface signed_nr_div_if #(
    parameter int N_WIDTH = 12,
    parameter int D_WIDTH = 6
);
    logic               load;
    logic [N_WIDTH-1:0] N;
    logic [D_WIDTH-1:0] D;
    logic               busy;
    logic               done;
    logic [N_WIDTH-1:0] Q;
    logic [D_WIDTH-1:0] R;
    logic               dz;
    logic               ovf;

    // Requester side: issues operands, observes results.
    modport master (
        output load, N, D,
        input  busy, done, Q, R, dz, ovf
    );

    // Divider side.
    modport slave (
        input  load, N, D,
        output busy, done, Q, R, dz, ovf
    );
endinterface

// File: rtl/signed_nr_div.sv
// Sequential signed divider: radix-2 non-restoring core on magnitudes, one
// quotient bit per cycle, followed by a sign/remainder correction step.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module signed_nr_div #(
    parameter int N_WIDTH = 12,
    parameter int D_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    signed_nr_div_if.slave   bus
);
    localparam int CW = $clog2(N_WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, ITER, CORR} state_t;

    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] n_cap_q, n_cap_d;   // captured dividend
    logic [D_WIDTH-1:0] d_cap_q, d_cap_d;   // captured divisor
    logic [N_WIDTH-1:0] qs_q, qs_d;         // |N| shifting out, quotient bits shifting in
    logic [D_WIDTH-1:0] dabs_q, dabs_d;     // |D|
    logic [D_WIDTH:0]   pr_q, pr_d;         // signed partial remainder
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d;     // quotient must be negated
    logic               rneg_q, rneg_d;     // remainder must be negated
    logic [N_WIDTH-1:0] q_q, q_d;
    logic [D_WIDTH-1:0] r_q, r_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    // Datapath helpers shared by the ITER and CORR steps.
    logic [D_WIDTH:0]   dabs_ext;
    logic [D_WIDTH:0]   pr_sh;
    logic [D_WIDTH:0]   pr_step;
    logic [D_WIDTH:0]   pr_fix;
    logic [D_WIDTH-1:0] pr_lo;
    logic [N_WIDTH-1:0] q_val;
    logic [D_WIDTH-1:0] r_val;
    logic               is_dz;
    logic               is_ovf;

    assign dabs_ext = {1'b0, dabs_q};
    assign pr_sh    = {pr_q[D_WIDTH-1:0], qs_q[N_WIDTH-1]};
    // Non-restoring step: subtract while the remainder is non-negative, add back otherwise.
    assign pr_step  = pr_q[D_WIDTH] ? (pr_sh + dabs_ext) : (pr_sh - dabs_ext);
    assign pr_fix   = pr_q[D_WIDTH] ? (pr_q + dabs_ext) : pr_q;
    assign pr_lo    = pr_fix[D_WIDTH-1:0];
    assign q_val    = qneg_q ? -qs_q : qs_q;
    assign r_val    = rneg_q ? -pr_lo : pr_lo;
    assign is_dz    = (d_cap_q == '0);
    assign is_ovf   = (n_cap_q == {1'b1, {(N_WIDTH-1){1'b0}}}) && (d_cap_q == '1);

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.dz   = dz_q;
    assign bus.ovf  = ovf_q;

    // Next-state and datapath update for every FSM state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d = state_q;
        n_cap_d = n_cap_q;
        d_cap_d = d_cap_q;
        qs_d    = qs_q;
        dabs_d  = dabs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    n_cap_d = bus.N;
                    d_cap_d = bus.D;
                    state_d = PREP;
                end
            end
            PREP: begin
                // The magnitude of the most negative value still fits as unsigned.
                qs_d    = n_cap_q[N_WIDTH-1] ? -n_cap_q : n_cap_q;
                dabs_d  = d_cap_q[D_WIDTH-1] ? -d_cap_q : d_cap_q;
                qneg_d  = n_cap_q[N_WIDTH-1] ^ d_cap_q[D_WIDTH-1];
                rneg_d  = n_cap_q[N_WIDTH-1];
                pr_d    = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                pr_d  = pr_step;
                qs_d  = {qs_q[N_WIDTH-2:0], ~pr_step[D_WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_WIDTH - 1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                pr_d    = pr_fix;
                q_d     = is_dz ? '1 : q_val;
                r_d     = (is_dz || is_ovf) ? '0 : r_val;
                dz_d    = is_dz;
                ovf_d   = is_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_cap_q <= '0;
            d_cap_q <= '0;
            qs_q    <= '0;
            dabs_q  <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            n_cap_q <= n_cap_d;
            d_cap_q <= d_cap_d;
            qs_q    <= qs_d;
            dabs_q  <= dabs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_signed_nr_div.sv
// Scoreboard bench for signed_nr_div: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_signed_nr_div;
    localparam int NW = 12;
    localparam int DW = 6;
    localparam int N_MIN = -(1 << (NW - 1));

    typedef struct {
        string name;
        int    n;
        int    d;
        int    q;
        int    r;
        bit    dz;
        bit    ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    signed_nr_div_if #(.N_WIDTH(NW), .D_WIDTH(DW)) bus ();

    signed_nr_div #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference arithmetic built on the language's own / and %.
    function automatic void model(input int n, input int d, output int q, output int r,
                                  output bit dz, output bit ovf);
        dz = 1'b0;
        ovf = 1'b0;
        if (d == 0) begin
            q = -1; r = 0; dz = 1'b1;
        end else if (n == N_MIN && d == -1) begin
            q = N_MIN; r = 0; ovf = 1'b1;
        end else begin
            q = n / d; r = n % d;
        end
    endfunction

    // Monitor: compare every done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_Q"}, int'($signed(bus.Q)), mon_e.q);
                check({mon_e.name, "_R"}, int'($signed(bus.R)), mon_e.r);
                check({mon_e.name, "_dz"}, int'(bus.dz), int'(mon_e.dz));
                check({mon_e.name, "_ovf"}, int'(bus.ovf), int'(mon_e.ovf));
                if (!mon_e.dz && !mon_e.ovf)
                    check({mon_e.name, "_QDR"},
                          int'($signed(bus.Q)) * mon_e.d + int'($signed(bus.R)), mon_e.n);
            end
        end
    end

    // One operation: push expectation, load, optionally pulse load while busy,
    // scramble inputs after capture, and check latency and busy width.
    task automatic run_op(input string name, input int n, input int d, input int q,
                          input int r, input bit dz, input bit ovf, input bit pulse_load);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        bit   seen;
        e.name = name; e.n = n; e.d = d; e.q = q; e.r = r; e.dz = dz; e.ovf = ovf;
        @(negedge clk);
        sb.push_back(e);
        bus.load = 1'b1;
        bus.N = NW'(n);
        bus.D = DW'(d);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.N = NW'($urandom);
        bus.D = DW'($urandom);
        check({name, "_busy_start"}, int'(bus.busy), 1);
        busy_cnt = 1;
        cyc = 0;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.busy === 1'b1) busy_cnt++;
                bus.load = pulse_load && (cyc == 3 || cyc == 8);
                if (bus.load) begin
                    bus.N = NW'($urandom);
                    bus.D = DW'($urandom);
                end
            end
        end
        bus.load = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done at 14", name, cyc);
        end else begin
            check({name, "_latency"}, cyc, NW + 2);
            check({name, "_busy_cycles"}, busy_cnt, NW + 2);
            check({name, "_busy_end"}, int'(bus.busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected bench end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q, r;
        bit dz, ovf;
        int n, d;
        logic signed [NW-1:0] rn;
        logic signed [DW-1:0] rd;

        bus.load = 1'b0;
        bus.N = '0;
        bus.D = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_Q", int'(bus.Q), 0);
        check("reset_R", int'(bus.R), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_dz", int'(bus.dz), 0);
        check("reset_ovf", int'(bus.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        run_op("p100_p7",   100,    7,   14,  2, 1'b0, 1'b0, 1'b0);
        run_op("m100_p7",  -100,    7,  -14, -2, 1'b0, 1'b0, 1'b0);
        run_op("p100_m7",   100,   -7,  -14,  2, 1'b0, 1'b0, 1'b0);
        run_op("m100_m7",  -100,   -7,   14, -2, 1'b0, 1'b0, 1'b0);
        run_op("ovf",     -2048,   -1,-2048,  0, 1'b0, 1'b1, 1'b0);
        run_op("zero_p5",     0,    5,    0,  0, 1'b0, 1'b0, 1'b0);
        run_op("dz",         37,    0,   -1,  0, 1'b1, 1'b0, 1'b0);
        run_op("min_m32", -2048,  -32,   64,  0, 1'b0, 1'b0, 1'b0);
        run_op("max_m32",  2047,  -32,  -63, 31, 1'b0, 1'b0, 1'b0);
        run_op("max_p31",  2047,   31,   66,  1, 1'b0, 1'b0, 1'b0);
        run_op("min_p31", -2048,   31,  -66, -2, 1'b0, 1'b0, 1'b0);
        run_op("min_p1",  -2048,    1,-2048,  0, 1'b0, 1'b0, 1'b0);
        run_op("ign_load",  100,    7,   14,  2, 1'b0, 1'b0, 1'b1);

        // Abort mid-iteration: outputs clear at once and no done follows.
        @(negedge clk);
        bus.load = 1'b1;
        bus.N = NW'(-100);
        bus.D = DW'(7);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_Q", int'(bus.Q), 0);
        check("abort_R", int'(bus.R), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        run_op("after_abort", -100, -7, 14, -2, 1'b0, 1'b0, 1'b0);

        // Random operand sweep against the reference model.
        for (int i = 0; i < 40; i++) begin
            rn = NW'($urandom);
            rd = DW'($urandom);
            n = int'(rn);
            d = int'(rd);
            model(n, d, q, r, dz, ovf);
            run_op($sformatf("rnd%0d", i), n, d, q, r, dz, ovf, 1'b0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
